pea_invoke_ctrl: RTL and testbench
==================================

PEA_INVOKE_CTRL -- requirements
Module: pea_invoke_ctrl

Interface
REQ-001 SHALL have parameter word_size, default 16, command/data word width.
REQ-002 SHALL have parameter buffer_size, default 1024, FIFO depth; FIFO-count width L = log2(buffer_size).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports command_pop, data_pop, result_free_space, status_free_space  input  L each  FIFO occupancy/free counts.
REQ-006 SHALL have port command_in  input  word_size  command FIFO read data, valid one cycle after command_rd_en.
REQ-007 SHALL have port command_rd_en  output  1  one-cycle command FIFO pop.
REQ-008 SHALL have port core_done  input  1  core completion pulse.
REQ-009 SHALL have ports core_start  output  1, core_mode  output  8, core_b  output  5, core_N  output  4  core firing request and arguments.
REQ-010 SHALL have ports busy  output  1, fire_count  output  16, err_count  output  8  status.

Function
REQ-011 Command decode SHALL be: mode = cmd[15:8]; b = cmd[4:0]; STP degree = cmd[3:0]; modes STP=0, EVP=1, EVB=2, RST=3.
REQ-012 FSM states SHALL be IDLE, FETCH, CHECK, FIRE, WAIT_DONE.
REQ-013 IDLE: readiness check in SETUP_INSTR mode; when command_pop >= 1, assert command_rd_en for exactly one cycle and go to FETCH.
REQ-014 FETCH: latch command_in into cmd_reg; go to CHECK.
REQ-015 CHECK: readiness check in INSTR mode with cmd_reg mode/b and N = (mode==STP ? cmd[3:0] : n_reg); stay until ready, then go to FIRE.
REQ-016 Readiness SHALL be: STP data_pop >= N+1, result/status free >= 1; EVP data_pop >= 1, result/status free >= b; EVB data_pop >= b, result/status free >= b; RST always; comparisons unsigned, N+1 computed at 5 bits.
REQ-017 CHECK with mode > 3, or EVP/EVB with b == 0: increment err_count (saturating at 255), no firing, return to IDLE next cycle.
REQ-018 FIRE: assert core_start for exactly one cycle; core_mode/core_b/core_N held stable from FIRE until leaving WAIT_DONE; go to WAIT_DONE.
REQ-019 WAIT_DONE: on core_done go to IDLE and increment fire_count (wraps 0xFFFF -> 0); core_done sampled only in WAIT_DONE, ignored elsewhere.
REQ-020 On firing of STP, n_reg SHALL load cmd[3:0]; on firing of RST, n_reg SHALL clear to 0.
REQ-021 busy SHALL be 0 only in IDLE.
REQ-022 Minimum command-to-command spacing SHALL be 5 cycles (IDLE, FETCH, CHECK, FIRE, WAIT_DONE with immediate done); back-to-back commands need no idle gap beyond this.
REQ-023 Occupancy inputs changing while in CHECK SHALL be re-evaluated every cycle; no latching.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, command_rd_en=0, core_start=0, core_mode=0, core_b=0, core_N=0, busy=0, fire_count=0, err_count=0, n_reg=0, cmd_reg=0.
REQ-025 Reset mid-operation (any state) SHALL abandon the in-flight command without firing or counting it; first pop possible on the first clock edge after rst deasserts.

Structure
REQ-026 Shared package SHALL hold mode encodings (STP/EVP/EVB/RST), next-mode encodings (SETUP_INSTR=2'b00, INSTR=2'b01), FSM state encodings, and the log2 function.
REQ-027 Readiness check SHALL be one instantiated sub-module, PEA_enable; FSM, counters and registers SHALL be local.

Verification
REQ-028 command_pop=1, cmd=0x0003 (STP N=3), data_pop=4, free=1/1, done 2 cycles after start -> one rd_en pulse, core_start at cycle 4, core_N=3, fire_count=1, n_reg=3.
REQ-029 cmd=0x0105 (EVP b=5), result_free_space=4 -> stall in CHECK, no core_start; raise to 5 -> core_start next cycle, core_b=5.
REQ-030 cmd=0x0700 (mode 7), then cmd=0x0200 (EVB b=0) -> err_count=2, no core_start, back to IDLE each time.
REQ-031 STP N=3 fired, then cmd=0x0300 (RST) -> fires unconditionally with zero data; n_reg=0; subsequent EVP uses core_N=0.
REQ-032 rst pulled low in WAIT_DONE with core_done arriving later -> immediate IDLE, all outputs zero, fire_count stays 0, late core_done ignored.
REQ-033 fire_count preloaded by 65535 firings then one more -> fire_count=0; 256 invalid commands -> err_count=255.

Source files
------------

// File: rtl/pea_invoke_ctrl_pkg.sv
// Shared encodings for the PEA invocation controller: command modes, readiness
// check modes, controller states and a constant-width helper.
package pea_invoke_ctrl_pkg;

    localparam logic [7:0] MODE_STP = 8'd0;
    localparam logic [7:0] MODE_EVP = 8'd1;
    localparam logic [7:0] MODE_EVB = 8'd2;
    localparam logic [7:0] MODE_RST = 8'd3;

    typedef enum logic [1:0] {
        SETUP_INSTR = 2'b00,
        INSTR       = 2'b01
    } next_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_FIRE      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    // Smallest r with 2**r >= value; used to size the FIFO count buses.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/PEA_enable.sv
// Readiness check: decides whether the FIFOs can accept the next step, either
// a command pop (SETUP_INSTR) or a core firing of the latched command (INSTR).
module PEA_enable
    import pea_invoke_ctrl_pkg::*;
#(
    parameter int L = 10
) (
    input  next_mode_e     next_mode_i,
    input  logic [7:0]     mode_i,
    input  logic [4:0]     b_i,
    input  logic [3:0]     n_i,
    input  logic [L-1:0]   command_pop_i,
    input  logic [L-1:0]   data_pop_i,
    input  logic [L-1:0]   result_free_i,
    input  logic [L-1:0]   status_free_i,
    output logic           enable_o
);

    localparam int CW = (L > 5) ? L : 5;

    logic [4:0]    n_plus_1;
    logic [CW-1:0] cp, dp, rf, sf, b_ext, np1_ext;

    // N+1 is formed at 5 bits so degree 15 needs 16 data words.
    assign n_plus_1 = {1'b0, n_i} + 5'd1;
    assign cp       = CW'(command_pop_i);
    assign dp       = CW'(data_pop_i);
    assign rf       = CW'(result_free_i);
    assign sf       = CW'(status_free_i);
    assign b_ext    = CW'(b_i);
    assign np1_ext  = CW'(n_plus_1);

    always_comb begin
        enable_o = 1'b0;
        if (next_mode_i == SETUP_INSTR) begin
            enable_o = (cp >= CW'(1));
        end else begin
            case (mode_i)
                MODE_STP: enable_o = (dp >= np1_ext) && (rf >= CW'(1)) && (sf >= CW'(1));
                MODE_EVP: enable_o = (dp >= CW'(1))  && (rf >= b_ext)  && (sf >= b_ext);
                MODE_EVB: enable_o = (dp >= b_ext)   && (rf >= b_ext)  && (sf >= b_ext);
                MODE_RST: enable_o = 1'b1;
                default:  enable_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pea_invoke_ctrl.sv
// PEA invocation controller: pops one command, waits until the FIFOs can
// serve it, fires the core once and waits for its completion pulse.
module pea_invoke_ctrl
    import pea_invoke_ctrl_pkg::*;
#(
    parameter  int word_size   = 16,
    parameter  int buffer_size = 1024,
    localparam int L           = log2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [L-1:0]         command_pop,
    input  logic [L-1:0]         data_pop,
    input  logic [L-1:0]         result_free_space,
    input  logic [L-1:0]         status_free_space,
    input  logic [word_size-1:0] command_in,
    output logic                 command_rd_en,
    input  logic                 core_done,
    output logic                 core_start,
    output logic [7:0]           core_mode,
    output logic [4:0]           core_b,
    output logic [3:0]           core_N,
    output logic                 busy,
    output logic [15:0]          fire_count,
    output logic [7:0]           err_count,
    output state_e               dbg_state_o
);

    state_e               state_q;
    logic [word_size-1:0] cmd_reg_q;
    logic [3:0]           n_reg_q;
    logic [7:0]           core_mode_q;
    logic [4:0]           core_b_q;
    logic [3:0]           core_n_q;
    logic [15:0]          fire_count_q;
    logic [7:0]           err_count_q;

    logic [7:0]  cmd_mode;
    logic [4:0]  cmd_b;
    logic [3:0]  chk_n;
    logic        cmd_invalid;
    logic        enable;
    logic        cmd_unused;
    next_mode_e  next_mode;

    assign cmd_mode    = cmd_reg_q[15:8];
    assign cmd_b       = cmd_reg_q[4:0];
    assign chk_n       = (cmd_mode == MODE_STP) ? cmd_reg_q[3:0] : n_reg_q;
    assign cmd_invalid = (cmd_mode > MODE_RST) ||
                         (((cmd_mode == MODE_EVP) || (cmd_mode == MODE_EVB)) && (cmd_b == 5'd0));
    assign next_mode   = (state_q == ST_IDLE) ? SETUP_INSTR : INSTR;
    assign cmd_unused  = ^cmd_reg_q;

    PEA_enable #(.L(L)) u_enable (
        .next_mode_i   (next_mode),
        .mode_i        (cmd_mode),
        .b_i           (cmd_b),
        .n_i           (chk_n),
        .command_pop_i (command_pop),
        .data_pop_i    (data_pop),
        .result_free_i (result_free_space),
        .status_free_i (status_free_space),
        .enable_o      (enable)
    );

    // Pop strobe is decoded from IDLE so the FIFO data is valid during FETCH.
    assign command_rd_en = (state_q == ST_IDLE) && enable;
    assign core_start    = (state_q == ST_FIRE);
    assign busy          = (state_q != ST_IDLE);
    assign core_mode     = core_mode_q;
    assign core_b        = core_b_q;
    assign core_N        = core_n_q;
    assign fire_count    = fire_count_q;
    assign err_count     = err_count_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cmd_reg_q    <= '0;
            n_reg_q      <= '0;
            core_mode_q  <= '0;
            core_b_q     <= '0;
            core_n_q     <= '0;
            fire_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    cmd_reg_q <= command_in;
                    state_q   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cmd_invalid) begin
                        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                        state_q <= ST_IDLE;
                    end else if (enable) begin
                        core_mode_q <= cmd_mode;
                        core_b_q    <= cmd_b;
                        core_n_q    <= chk_n;
                        if (cmd_mode == MODE_STP) n_reg_q <= cmd_reg_q[3:0];
                        if (cmd_mode == MODE_RST) n_reg_q <= 4'd0;
                        state_q <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (core_done) begin
                        fire_count_q <= fire_count_q + 16'd1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pea_invoke_ctrl.sv
// Bench for pea_invoke_ctrl: directed scenarios plus randomized command traffic
// checked every cycle against a transaction-level model of the controller.
module tb_pea_invoke_ctrl;
    import pea_invoke_ctrl_pkg::*;

    localparam int L = log2(1024);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [L-1:0]   command_pop = '0, data_pop = '0, result_free_space = '0, status_free_space = '0;
    logic [15:0]    command_in = '0;
    logic           command_rd_en, core_done = 1'b0, core_start, busy;
    logic [7:0]     core_mode, err_count;
    logic [4:0]     core_b;
    logic [3:0]     core_N;
    logic [15:0]    fire_count;
    state_e         dbg_state;

    pea_invoke_ctrl #(.word_size(16), .buffer_size(1024)) dut (
        .clk(clk), .rst(rst),
        .command_pop(command_pop), .data_pop(data_pop),
        .result_free_space(result_free_space), .status_free_space(status_free_space),
        .command_in(command_in), .command_rd_en(command_rd_en), .core_done(core_done),
        .core_start(core_start), .core_mode(core_mode), .core_b(core_b), .core_N(core_N),
        .busy(busy), .fire_count(fire_count), .err_count(err_count), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus knobs ----------------
    logic [15:0] cmd_fifo[$];    // commands still sitting in the command FIFO
    bit  hold_pop   = 1'b1;
    bit  rand_occ   = 1'b0;
    int  dp_fix = 0, rf_fix = 0, sf_fix = 0;
    int  done_mode  = 0;         // 0 random pulses, 1 fixed delay after start, 2 never
    int  done_delay = 2;

    // ---------------- model state ----------------
    logic [15:0] exp_q[$];       // fired commands awaiting their core_start
    int          cyc = 0;
    bit          m_busy = 0, m_waiting = 0;
    int          m_rd_t = 0, m_fire_t = -1, m_n = 0, m_err = 0;
    logic [15:0] m_cmd = '0, m_fire_cnt = '0;
    logic [7:0]  e_mode = '0;
    logic [4:0]  e_b = '0;
    logic [3:0]  e_n = '0;
    bit          feed_valid = 0;
    logic [15:0] feed_val = '0;

    int obs_rd_cnt = 0, obs_rd_t = 0, obs_start_cnt = 0, obs_start_t = 0;
    int obs_core_n = 0, obs_core_b = 0;

    function automatic bit ready_f(int mode, int b, int n, int dp, int rf, int sf);
        case (mode)
            0: return (dp >= n + 1) && (rf >= 1) && (sf >= 1);
            1: return (dp >= 1) && (rf >= b) && (sf >= b);
            2: return (dp >= b) && (rf >= b) && (sf >= b);
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit invalid_f(logic [15:0] c);
        int mode = int'(c[15:8]);
        int b    = int'(c[4:0]);
        return (mode > 3) || ((mode == 1 || mode == 2) && b == 0);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_waiting = 0; m_fire_t = -1; m_n = 0; m_err = 0;
        m_fire_cnt = '0; feed_valid = 0;
        exp_q.delete();
    endtask

    // ---------------- driver + compare (one step per cycle) ----------------
    initial begin
        int n;
        bit pop_now;
        logic [15:0] fired;
        forever begin
            @(negedge clk);
            n = cmd_fifo.size();
            if (n > 8) n = 8;
            if (hold_pop || (rand_occ && $urandom_range(0, 3) == 0)) n = 0;
            command_pop = L'(n);
            command_in  = feed_valid ? feed_val : 16'($urandom);
            feed_valid  = 0;
            if (rand_occ) begin
                data_pop          = L'($urandom_range(0, 18));
                result_free_space = L'($urandom_range(0, 12));
                status_free_space = L'($urandom_range(0, 12));
            end else begin
                data_pop          = L'(dp_fix);
                result_free_space = L'(rf_fix);
                status_free_space = L'(sf_fix);
            end
            case (done_mode)
                0:       core_done = ($urandom_range(0, 2) == 0);
                1:       core_done = (m_fire_t >= 0) && (cyc == m_fire_t + done_delay);
                default: core_done = 1'b0;
            endcase
            #1;
            if (!rst) begin
                model_reset();
            end else begin
                if (command_rd_en) begin obs_rd_cnt++; obs_rd_t = cyc; end
                if (core_start) begin
                    obs_start_cnt++; obs_start_t = cyc;
                    obs_core_n = int'(core_N); obs_core_b = int'(core_b);
                end
                chk("fire_count", fire_count, m_fire_cnt);
                chk("err_count", err_count, m_err);
                if (!m_busy) begin
                    pop_now = (n >= 1);
                    chk("busy_idle", busy, 0);
                    chk("rd_en", command_rd_en, pop_now);
                    chk("start_idle", core_start, 0);
                    if (pop_now) begin
                        m_busy = 1; m_waiting = 0; m_fire_t = -1; m_rd_t = cyc;
                        m_cmd = cmd_fifo.pop_front();
                        feed_valid = 1; feed_val = m_cmd;
                    end
                end else begin
                    chk("busy", busy, 1);
                    chk("rd_en_busy", command_rd_en, 0);
                    if (m_waiting) begin
                        chk("start_wait", core_start, 0);
                        chk("mode_hold", core_mode, e_mode);
                        chk("b_hold", core_b, e_b);
                        chk("n_hold", core_N, e_n);
                        if (core_done) begin
                            m_fire_cnt = m_fire_cnt + 16'd1;
                            m_busy = 0; m_fire_t = -1;
                        end
                    end else if (m_fire_t == cyc) begin
                        chk("start", core_start, 1);
                        fired = exp_q.pop_front();
                        chk("core_mode", core_mode, fired[15:8]);
                        chk("core_b", core_b, e_b);
                        chk("core_N", core_N, e_n);
                        if (fired[15:8] == 8'd0) m_n = int'(fired[3:0]);
                        if (fired[15:8] == 8'd3) m_n = 0;
                        m_waiting = 1;
                    end else begin
                        chk("start_early", core_start, 0);
                        // The command is under examination from two cycles after its pop.
                        if (cyc >= m_rd_t + 2) begin
                            if (invalid_f(m_cmd)) begin
                                if (m_err < 255) m_err++;
                                m_busy = 0;
                            end else begin
                                e_n = (m_cmd[15:8] == 8'd0) ? m_cmd[3:0] : 4'(m_n);
                                if (ready_f(int'(m_cmd[15:8]), int'(m_cmd[4:0]), int'(e_n),
                                            int'(data_pop), int'(result_free_space),
                                            int'(status_free_space))) begin
                                    m_fire_t = cyc + 1;
                                    e_mode = m_cmd[15:8];
                                    e_b = m_cmd[4:0];
                                    exp_q.push_back(m_cmd);
                                end
                            end
                        end
                    end
                end
                cyc++;
            end
        end
    end

    // ---------------- helpers for the directed sequence ----------------
    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((cmd_fifo.size() != 0 || m_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        checks++;
        if (cmd_fifo.size() != 0 || m_busy) begin
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, budget);
        end
    endtask

    task automatic set_occ(input int dp, input int rf, input int sf);
        dp_fix = dp; rf_fix = rf; sf_fix = sf;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        logic [7:0] bad_mode;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", command_rd_en, 0);
        chk("rst_start", core_start, 0);
        chk("rst_fire_count", fire_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_core_fields", {core_mode, core_b, core_N}, 0);
        #2 rst = 1'b1;
        hold_pop = 1'b0;

        // STP N=3 with exactly enough data, done two cycles after start.
        done_mode = 1; done_delay = 2; set_occ(4, 1, 1);
        @(posedge clk);
        cmd_fifo.push_back(16'h0003);
        wait_idle(40, "stp");
        chk("stp_rd_pulses", obs_rd_cnt, 1);
        chk("stp_start_count", obs_start_cnt, 1);
        chk("stp_latency", obs_start_t - obs_rd_t, 3);
        chk("stp_core_n", obs_core_n, 3);
        chk("stp_fire_count", fire_count, 1);

        // EVP b=5 stalls on result space 4, fires once it reaches 5.
        set_occ(8, 4, 8);
        cmd_fifo.push_back(16'h0105);
        repeat (10) @(posedge clk);
        chk("evp_stall_start", obs_start_cnt, 1);
        chk("evp_stall_busy", busy, 1);
        set_occ(8, 5, 8);
        repeat (3) @(posedge clk);
        chk("evp_start_count", obs_start_cnt, 2);
        chk("evp_core_b", obs_core_b, 5);
        wait_idle(40, "evp");

        // Invalid mode and EVB with b=0 both count as errors without firing.
        cmd_fifo.push_back(16'h0700);
        cmd_fifo.push_back(16'h0200);
        wait_idle(40, "invalid");
        chk("invalid_err_count", err_count, 2);
        chk("invalid_start_count", obs_start_cnt, 2);

        // RST fires with empty FIFOs and clears the remembered degree.
        set_occ(4, 1, 1);
        cmd_fifo.push_back(16'h0003);
        wait_idle(40, "stp2");
        set_occ(0, 0, 0);
        cmd_fifo.push_back(16'h0300);
        wait_idle(40, "rst_cmd");
        chk("rst_cmd_fired", obs_start_cnt, 4);
        set_occ(1, 5, 5);
        cmd_fifo.push_back(16'h0105);
        wait_idle(40, "evp_after_rst");
        chk("evp_after_rst_core_n", obs_core_n, 0);
        chk("fire_count_after_rst_cmd", fire_count, 5);

        // Reset while waiting for done; late done pulses must not count.
        hold_pop = 1'b1;
        do_reset();
        hold_pop = 1'b0;
        done_mode = 2; set_occ(4, 1, 1);
        cmd_fifo.push_back(16'h0003);
        s0 = 0;
        while (!m_waiting && s0 < 20) begin @(posedge clk); s0++; end
        chk("mid_reached_wait", m_waiting, 1);
        @(posedge clk);
        hold_pop = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_core_fields", {core_mode, core_b, core_N}, 0);
        chk("mid_rst_fire_count", fire_count, 0);
        done_mode = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("late_done_fire_count", fire_count, 0);
        chk("late_done_busy", busy, 0);
        hold_pop = 1'b0;

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            bad_mode = 8'($urandom_range(4, 255));
            if (i % 3 == 0) cmd_fifo.push_back(16'h0200);
            else            cmd_fifo.push_back({bad_mode, 8'($urandom)});
        end
        wait_idle(260 * 6, "err_sat");
        chk("err_saturated", err_count, 255);

        // Randomized traffic.
        rand_occ = 1'b1; done_mode = 0;
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] md;
            logic [4:0] b;
            b = 5'($urandom_range(0, 9));
            if (r <= 2)      md = 8'd0;
            else if (r <= 4) md = 8'd1;
            else if (r <= 6) md = 8'd2;
            else if (r == 7) md = 8'd3;
            else             md = 8'($urandom_range(4, 255));
            cmd_fifo.push_back({md, 3'($urandom), b});
        end
        wait_idle(400 * 60, "random");
        chk("random_fire_count", fire_count, m_fire_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
